// File: rtl/vram_arbiter.sv
// Video RAM arbiter: a display pipeline with fixed two-cycle read latency has priority,
// and a starvation counter forces a CPU access through when the display keeps the RAM busy.
module vram_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 8,
  parameter int STARVE_MAX = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_rvalid,
  output logic [DATA_W-1:0] vid_rdata,
  output logic              vid_drop,
  output logic [7:0]        vid_drop_cnt,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DATA  = 2'd2
  } cpu_state_t;

  cpu_state_t        state;
  logic [7:0]        wait_cnt;
  logic              cpu_is_read;
  logic [1:0]        vid_pipe;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic              force_grant;
  logic              cpu_grant;
  logic              vid_grant;

  always_comb begin
    // NOTE: every signal gets a default before any condition so no path infers a latch.
    force_grant = 1'b0;
    cpu_grant   = 1'b0;
    vid_grant   = vid_req;
    if (state == IDLE && cpu_req) begin
      force_grant = vid_req && (wait_cnt == STARVE_LIM);
      cpu_grant   = !vid_req || force_grant;
      vid_grant   = vid_req && !force_grant;
    end
  end

  // Read data is taken straight off the RAM bus in the return cycle; the CPU side
  // keeps its last read value between reads.
  assign vid_drop   = force_grant;
  assign vid_rvalid = vid_pipe[1];
  assign vid_rdata  = vid_pipe[1] ? mem_rdata : '0;
  assign cpu_rdata  = (cpu_ack && cpu_is_read) ? mem_rdata : cpu_rdata_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      vid_pipe     <= '0;
      vid_drop_cnt <= '0;
      wait_cnt     <= '0;
      cpu_is_read  <= 1'b0;
      cpu_rdata_q  <= '0;
      cpu_ack      <= 1'b0;
      state        <= IDLE;
    end else begin
      // NOTE: all state updates are non-blocking so every flop samples pre-edge values.
      mem_en   <= cpu_grant || vid_grant;
      mem_we   <= cpu_grant && cpu_we;
      vid_pipe <= {vid_pipe[0], vid_grant};
      if (cpu_grant) begin
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end else if (vid_grant) begin
        mem_addr  <= vid_addr;
      end

      if (force_grant && vid_drop_cnt != 8'hFF)
        vid_drop_cnt <= vid_drop_cnt + 8'd1;

      // Only cycles lost to video while waiting in IDLE count toward starvation.
      if (cpu_grant || !cpu_req)
        wait_cnt <= '0;
      else if (state == IDLE && vid_req)
        wait_cnt <= wait_cnt + 8'd1;

      if (cpu_ack && cpu_is_read)
        cpu_rdata_q <= mem_rdata;

      cpu_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_grant) begin
            state       <= ISSUE;
            cpu_is_read <= !cpu_we;
          end
        end
        ISSUE: begin
          state   <= DATA;
          cpu_ack <= 1'b1;
        end
        DATA:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: CPU write/read, paced and back-to-back video,
// starvation-forced grant, reset mid-transaction and drop-counter saturation.
module tb_vram_arbiter;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              vid_req = 1'b0;
  logic [ADDR_W-1:0] vid_addr = '0;
  logic              vid_rvalid;
  logic [DATA_W-1:0] vid_rdata;
  logic              vid_drop;
  logic [7:0]        vid_drop_cnt;
  logic              cpu_req = 1'b0;
  logic              cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;

  int total = 0;
  int bad   = 0;

  vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(7)) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_rvalid(vid_rvalid),
    .vid_rdata(vid_rdata), .vid_drop(vid_drop), .vid_drop_cnt(vid_drop_cnt),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Unwritten RAM locations read back a fixed address-derived pattern.
  function automatic logic [7:0] pat(input logic [15:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  logic [7:0] ram [int];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[int'(mem_addr)] = mem_wdata;
      else mem_rdata <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : pat(mem_addr);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_mem_en"}, 32'(mem_en), 0);
    check({tag, "_mem_we"}, 32'(mem_we), 0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
    check({tag, "_vid_rvalid"}, 32'(vid_rvalid), 0);
    check({tag, "_vid_rdata"}, 32'(vid_rdata), 0);
    check({tag, "_vid_drop"}, 32'(vid_drop), 0);
    check({tag, "_drop_cnt"}, 32'(vid_drop_cnt), 0);
    check({tag, "_cpu_ack"}, 32'(cpu_ack), 0);
    check({tag, "_cpu_rdata"}, 32'(cpu_rdata), 0);
  endtask

  int n_rvalid;
  int drops;
  logic ack_prev;
  logic exp_v;

  initial begin
    // Reset state
    cyc(); cyc(); #1;
    check_all_zero("rst");

    // CPU write 0x0010 <= 0xA5, issued in the very first cycle after reset release
    cyc();
    reset = 1'b0;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0010; cpu_wdata = 8'hA5;
    #1 check("wr_ack_n0", 32'(cpu_ack), 0);
    cyc(); #1;
    check("wr_mem_en", 32'(mem_en), 1);
    check("wr_mem_we", 32'(mem_we), 1);
    check("wr_mem_addr", 32'(mem_addr), 32'h0010);
    check("wr_mem_wdata", 32'(mem_wdata), 32'hA5);
    check("wr_ack_n1", 32'(cpu_ack), 0);
    cyc(); #1;
    check("wr_ack_n2", 32'(cpu_ack), 1);
    check("wr_mem_en_idle", 32'(mem_en), 0);
    check("wr_addr_hold", 32'(mem_addr), 32'h0010);
    cyc();
    cpu_req = 1'b0;
    #1 check("wr_ack_n3", 32'(cpu_ack), 0);

    // CPU read back 0x0010
    cyc();
    cpu_req = 1'b1; cpu_we = 1'b0;
    cyc(); #1;
    check("rd_mem_en", 32'(mem_en), 1);
    check("rd_mem_we", 32'(mem_we), 0);
    cyc(); #1;
    check("rd_ack", 32'(cpu_ack), 1);
    check("rd_data", 32'(cpu_rdata), 32'hA5);
    cyc();
    cpu_req = 1'b0;

    // CPU write elsewhere: cpu_rdata must keep the last read value
    cyc();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0020; cpu_wdata = 8'h3C;
    cyc(); cyc(); #1;
    check("wr2_ack", 32'(cpu_ack), 1);
    check("wr2_rdata_hold", 32'(cpu_rdata), 32'hA5);
    cyc();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0010;

    // Video reads every other cycle, addresses 0..9
    n_rvalid = 0;
    for (int c = 0; c < 23; c++) begin
      cyc();
      vid_req  = (c < 20) && (c % 2 == 0);
      vid_addr = 16'(c / 2);
      #1;
      exp_v = (c >= 2) && (c < 22) && (c % 2 == 0);
      check($sformatf("vid_rvalid_c%0d", c), 32'(vid_rvalid), 32'(exp_v));
      if (exp_v) check($sformatf("vid_rdata_c%0d", c), 32'(vid_rdata), 32'(pat(16'((c - 2) / 2))));
      if (vid_rvalid) n_rvalid++;
    end
    check("vid_rvalid_count", 32'(n_rvalid), 10);

    // Back-to-back video with CPU read held: forced grant on the 8th cycle
    for (int c = 0; c < 14; c++) begin
      cyc();
      vid_req  = (c <= 12);
      vid_addr = 16'h0100 + 16'(c);
      cpu_req  = (c <= 9);
      cpu_we   = 1'b0;
      cpu_addr = 16'h0010;
      #1;
      check($sformatf("st_drop_c%0d", c), 32'(vid_drop), 32'(c == 7));
      exp_v = (c >= 2) && (c - 2 != 7) && (c - 2 <= 12);
      check($sformatf("st_rvalid_c%0d", c), 32'(vid_rvalid), 32'(exp_v));
      if (exp_v) check($sformatf("st_rdata_c%0d", c), 32'(vid_rdata), 32'(pat(16'h0100 + 16'(c - 2))));
      check($sformatf("st_ack_c%0d", c), 32'(cpu_ack), 32'(c == 9));
      if (c == 8) begin
        check("st_mem_en", 32'(mem_en), 1);
        check("st_mem_we", 32'(mem_we), 0);
        check("st_mem_addr", 32'(mem_addr), 32'h0010);
        check("st_drop_cnt", 32'(vid_drop_cnt), 1);
      end
      if (c == 9) check("st_cpu_rdata", 32'(cpu_rdata), 32'hA5);
    end

    // Reset asserted while the CPU is in ISSUE with a video read being granted
    cyc();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010; vid_req = 1'b0;
    cyc();
    vid_req = 1'b1; vid_addr = 16'h0007;
    #1 check("rs_mem_en_issue", 32'(mem_en), 1);
    reset = 1'b1;
    #1;
    check_all_zero("rs_async");
    cpu_req = 1'b0; vid_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cyc(); #1;
      check($sformatf("rs_ack_c%0d", c), 32'(cpu_ack), 0);
      check($sformatf("rs_rvalid_c%0d", c), 32'(vid_rvalid), 0);
    end
    cyc();
    reset = 1'b0;
    cpu_req = 1'b1;
    cyc(); #1;
    check("rs_fresh_mem_en", 32'(mem_en), 1);
    check("rs_fresh_rvalid", 32'(vid_rvalid), 0);
    cyc(); #1;
    check("rs_fresh_ack", 32'(cpu_ack), 1);
    check("rs_fresh_rdata", 32'(cpu_rdata), 32'hA5);
    check("rs_fresh_rvalid2", 32'(vid_rvalid), 0);
    cyc();
    cpu_req = 1'b0;

    // 300 forced drops: the counter saturates at 255
    drops = 0;
    ack_prev = 1'b1;
    for (int c = 0; c < 6000 && drops < 300; c++) begin
      cyc();
      vid_req  = 1'b1;
      vid_addr = 16'(c);
      cpu_req  = !ack_prev;
      #1;
      if (vid_drop) drops++;
      ack_prev = cpu_ack;
    end
    cyc();
    vid_req = 1'b0; cpu_req = 1'b0;
    #1;
    check("sat_drops_seen", 32'(drops), 300);
    check("sat_drop_cnt", 32'(vid_drop_cnt), 255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
